// File: rtl/instr_fetch_unit_if.sv
// Bus between the processor top and the fetch stage: control and program-load
// inputs travel toward the fetch unit, and the fetched instruction comes back.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              run;
  logic              stall;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [DATA_W-1:0] imem_wdata;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              instr_valid;
  logic              halted;

  modport master (
    output run, stall, branch_valid, branch_target,
    output imem_we, imem_waddr, imem_wdata,
    input  instr_out, pc_out, instr_valid, halted
  );

  modport slave (
    input  run, stall, branch_valid, branch_target,
    input  imem_we, imem_waddr, imem_wdata,
    output instr_out, pc_out, instr_valid, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, instruction memory with a registered read port,
// and the IDLE/FETCH/HALT sequencing that feeds decode one word per cycle.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 6,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 2 ** ADDR_W,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               clkreset,
  instr_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pc_out_q, pc_out_nxt;
  logic [DATA_W-1:0] instr_q, instr_nxt;
  logic              valid_q, valid_nxt;
  logic              halted_q, halted_nxt;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem [DEPTH];

  // Program-load port; contents survive reset. The fetch register below samples
  // the pre-write value on a same-address collision.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  assign rd_word = mem[pc];

  always_ff @(posedge clk or negedge clkreset) begin
    if (!clkreset) begin
      state    <= IDLE;
      pc       <= '0;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr_q  <= instr_nxt;
      pc_out_q <= pc_out_nxt;
      valid_q  <= valid_nxt;
      halted_q <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    instr_nxt  = instr_q;
    pc_out_nxt = pc_out_q;
    valid_nxt  = valid_q;
    halted_nxt = halted_q;

    unique case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        if (bus.run) begin
          state_nxt = FETCH;
        end
      end

      FETCH: begin
        // A redirect outranks stall so a taken branch is never lost behind a
        // busy decoder; the halt word is still delivered before stopping.
        if (!bus.run) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else if (bus.branch_valid) begin
          pc_nxt    = bus.branch_target;
          valid_nxt = 1'b0;
        end else if (!bus.stall) begin
          instr_nxt  = rd_word;
          pc_out_nxt = pc;
          valid_nxt  = 1'b1;
          if (rd_word == HALT_WORD) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end else begin
            pc_nxt = pc + ADDR_W'(1);
          end
        end
      end

      HALT: begin
        if (!bus.run) begin
          state_nxt  = IDLE;
          pc_nxt     = '0;
          halted_nxt = 1'b0;
          valid_nxt  = 1'b0;
        end else if (!bus.stall) begin
          valid_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt  = IDLE;
        valid_nxt  = 1'b0;
        halted_nxt = 1'b0;
      end
    endcase
  end

  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch_unit;

  localparam int          ADDR_W    = 6;
  localparam int          DATA_W    = 32;
  localparam int          DEPTH     = 64;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic clkreset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   check_en     = 1'b0;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .HALT_WORD(HALT_WORD)
  ) dut (
    .clk(clk),
    .clkreset(clkreset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: a program counter walking a word array, with a running flag and
  // a stopped flag; memory is updated after the fetch so reads see old data.
  logic [31:0] m_mem [DEPTH];
  int          m_pc;
  int          m_pc_out;
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_active;

  always @(posedge clk or negedge clkreset) begin
    logic [31:0] word;
    if (!clkreset) begin
      m_pc = 0; m_pc_out = 0; m_instr = 0;
      m_valid = 0; m_halted = 0; m_active = 0;
    end else begin
      word = m_mem[m_pc];
      if (m_halted) begin
        if (!bus.run) begin
          m_halted = 0; m_pc = 0; m_valid = 0;
        end else if (!bus.stall) begin
          m_valid = 0;
        end
      end else if (!m_active) begin
        m_valid = 0;
        if (bus.run) m_active = 1;
      end else if (!bus.run) begin
        m_active = 0; m_valid = 0;
      end else if (bus.branch_valid) begin
        m_pc = int'(bus.branch_target); m_valid = 0;
      end else if (!bus.stall) begin
        m_instr = word; m_pc_out = m_pc; m_valid = 1;
        if (word == HALT_WORD) begin
          m_halted = 1; m_active = 0;
        end else begin
          m_pc = (m_pc + 1) % DEPTH;
        end
      end
      if (bus.imem_we) m_mem[int'(bus.imem_waddr)] = bus.imem_wdata;
    end
  end

  task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      compareField("model instr_out", bus.instr_out, m_instr);
      compareField("model pc_out", 32'(bus.pc_out), 32'(m_pc_out));
      compareField("model instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      compareField("model halted", 32'(bus.halted), 32'(m_halted));
    end
  end

  task automatic applyStimulus(input bit run, input bit stall, input bit br, input int target,
                               input bit we, input int waddr, input logic [31:0] wdata);
    bus.run           = run;
    bus.stall         = stall;
    bus.branch_valid  = br;
    bus.branch_target = 6'(target);
    bus.imem_we       = we;
    bus.imem_waddr    = 6'(waddr);
    bus.imem_wdata    = wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] instr, input int pc_out,
                             input bit valid, input bit halted, input bit wait_edge);
    if (wait_edge) @(negedge clk);
    compareField({name, " instr_out"}, bus.instr_out, instr);
    compareField({name, " pc_out"}, 32'(bus.pc_out), 32'(pc_out));
    compareField({name, " instr_valid"}, 32'(bus.instr_valid), 32'(valid));
    compareField({name, " halted"}, 32'(bus.halted), 32'(halted));
  endtask

  function automatic logic [31:0] initWord(input int i);
    logic [31:0] w;
    w = $urandom();
    if (w == HALT_WORD) w = 32'h0;
    case (i)
      0:  w = 32'h11;
      1:  w = 32'h22;
      2:  w = 32'h33;
      3:  w = 32'h44;
      4:  w = 32'h55;
      6:  w = 32'h66;
      10: w = 32'hAA;
      62: w = 32'h1;
      63: w = 32'h2;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    clkreset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 32'h0, 0, 0, 0, 0);
    clkreset = 1'b1;
    check_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 0, 0, 1, i, initWord(i));
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("after load", 32'h0, 0, 0, 0, 1);

    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("idle edge", 32'h0, 0, 0, 0, 1);
    checkOutput("fetch0", 32'h11, 0, 1, 0, 1);
    checkOutput("fetch1", 32'h22, 1, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) checkOutput("stall hold", 32'h22, 1, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("after stall", 32'h33, 2, 1, 0, 1);

    applyStimulus(1, 0, 1, 10, 0, 0, 32'h0);
    checkOutput("branch bubble", 32'h33, 2, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("branch target", 32'hAA, 10, 1, 0, 1);
    applyStimulus(1, 1, 1, 10, 0, 0, 32'h0);
    checkOutput("branch+stall bubble", 32'hAA, 10, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("branch+stall target", 32'hAA, 10, 1, 0, 1);

    applyStimulus(0, 0, 0, 0, 1, 0, 32'h3);
    checkOutput("pause", 32'hAA, 10, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 5, HALT_WORD);
    checkOutput("idle hold", 32'hAA, 10, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("resume edge", 32'hAA, 10, 0, 0, 1);
    applyStimulus(1, 0, 1, 62, 0, 0, 32'h0);
    checkOutput("wrap bubble", 32'hAA, 10, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("wrap62", 32'h1, 62, 1, 0, 1);
    checkOutput("wrap63", 32'h2, 63, 1, 0, 1);
    checkOutput("wrap0", 32'h3, 0, 1, 0, 1);

    applyStimulus(1, 0, 1, 6, 0, 0, 32'h0);
    checkOutput("to6 bubble", 32'h3, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("fetch6", 32'h66, 6, 1, 0, 1);
    #2 clkreset = 1'b0;
    #1 checkOutput("async reset", 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    clkreset = 1'b1;
    checkOutput("restart idle", 32'h0, 0, 0, 0, 1);
    checkOutput("restart0", 32'h3, 0, 1, 0, 1);
    checkOutput("restart1", 32'h22, 1, 1, 0, 1);
    checkOutput("restart2", 32'h33, 2, 1, 0, 1);
    checkOutput("restart3", 32'h44, 3, 1, 0, 1);
    checkOutput("restart4", 32'h55, 4, 1, 0, 1);
    checkOutput("halt word", HALT_WORD, 5, 1, 1, 1);
    checkOutput("halted", HALT_WORD, 5, 0, 1, 1);
    applyStimulus(1, 0, 1, 20, 0, 0, 32'h0);
    checkOutput("halt ignores branch", HALT_WORD, 5, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("halt release", HALT_WORD, 5, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("rerun idle", HALT_WORD, 5, 0, 0, 1);
    checkOutput("rerun0", 32'h3, 0, 1, 0, 1);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!clkreset) begin
        clkreset = 1'b1;
      end
      bus.run           = ($urandom_range(24) != 0);
      bus.stall         = ($urandom_range(3) == 0);
      bus.branch_valid  = ($urandom_range(9) == 0);
      bus.branch_target = 6'($urandom_range(63));
      bus.imem_we       = ($urandom_range(6) == 0);
      bus.imem_waddr    = ($urandom_range(2) == 0) ? 6'(m_pc) : 6'($urandom_range(63));
      bus.imem_wdata    = ($urandom_range(15) == 0) ? HALT_WORD : 32'($urandom());
      if (clkreset && $urandom_range(199) == 0) begin
        bus.imem_we = 1'b0;
        #2 clkreset = 1'b0;
      end
    end

    @(negedge clk);
    clkreset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
